// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Arbitrates the register file's single write port between the in-order
// pipeline writeback stage (priority, zero latency) and a long-latency unit
// (mul/div, uncached loads) that hands results over through a valid/ready
// handshake into a small FIFO. Queued destinations are exported as a pending
// mask for the hazard unit. A stall request is raised when the queue head
// has been blocked by pipeline writebacks for STARVE_LIMIT consecutive edges.
//
// Ports
//   clk_i, reset_i        clock (rising edge) and synchronous active-high reset
//   wb_reg_write_i        pipeline writeback valid
//   wb_rd_i, wb_result_i  pipeline destination / result
//   ll_valid_i            long-latency result valid
//   ll_ready_o            queue can accept (registered count < DEPTH)
//   ll_rd_i, ll_result_i  long-latency destination / result
//   a3_o, wd3_o, we3_o    register file write address / data / enable
//   pending_o             bit i set while a queued entry targets x_i
//   stall_o               request to freeze upstream stages
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wb_reg_write_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [WIDTH-1:0] wb_result_i,
  input  logic             ll_valid_i,
  output logic             ll_ready_o,
  input  logic [4:0]       ll_rd_i,
  input  logic [WIDTH-1:0] ll_result_i,
  output logic [4:0]       a3_o,
  output logic [WIDTH-1:0] wd3_o,
  output logic             we3_o,
  output logic [31:0]      pending_o,
  output logic             stall_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  // Queue storage and state
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q,  valid_d;
  logic [AW-1:0]    rptr_q,   rptr_d;
  logic [AW-1:0]    wptr_q,   wptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [SW-1:0]    starve_q, starve_d;

  logic pipe_claim;
  logic q_empty;
  logic deq;
  logic enq_store;
  logic [31:0] pending_mask;

  // Handshake and arbitration decisions
  always_comb begin
    pipe_claim = wb_reg_write_i && (wb_rd_i != 5'd0);
    q_empty    = (count_q == '0);
    // Ready comes from the registered count only, so a same-cycle drain
    // never opens a slot combinationally.
    ll_ready_o = !reset_i && (count_q < DEPTH_C);
    deq        = !reset_i && !pipe_claim && !q_empty;
    // An x0 handshake completes but occupies no slot.
    enq_store  = ll_valid_i && ll_ready_o && (ll_rd_i != 5'd0);
  end

  // Write port mux: pipeline first, then queue head, else idle zeros
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would otherwise infer a latch.
    a3_o  = 5'd0;
    wd3_o = '0;
    we3_o = 1'b0;
    if (!reset_i) begin
      if (pipe_claim) begin
        a3_o  = wb_rd_i;
        wd3_o = wb_result_i;
        we3_o = 1'b1;
      end else if (!q_empty) begin
        a3_o  = rd_mem_q[rptr_q];
        wd3_o = data_mem_q[rptr_q];
        we3_o = 1'b1;
      end
    end
  end

  // Next-state for pointers, count, valid bits and starvation counter
  always_comb begin
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    starve_d = starve_q;

    if (deq) begin
      rptr_d          = rptr_q + AW'(1);
      valid_d[rptr_q] = 1'b0;
    end
    if (enq_store) begin
      wptr_d          = wptr_q + AW'(1);
      valid_d[wptr_q] = 1'b1;
    end

    unique case ({enq_store, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Counts edges where the head is blocked by a pipeline claim.
    if (q_empty || deq) begin
      starve_d = '0;
    end else if (pipe_claim && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      starve_q <= '0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      starve_q <= starve_d;
    end
  end

  // NOTE: the payload arrays carry no reset; valid_q and count_q gate every
  // use of them, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (enq_store) begin
      rd_mem_q[wptr_q]   <= ll_rd_i;
      data_mem_q[wptr_q] <= ll_result_i;
    end
  end

  // Pending mask from registered storage
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        pending_mask = pending_mask | (32'd1 << rd_mem_q[i]);
      end
    end
    pending_mask[0] = 1'b0;
    pending_o = reset_i ? 32'd0 : pending_mask;
  end

  assign stall_o = !reset_i && (starve_q == LIMIT_C);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_res;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_res;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        we3;
  logic [31:0] pending;
  logic        stall;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter #(.WIDTH(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .wb_reg_write_i (wb_we),
    .wb_rd_i        (wb_rd),
    .wb_result_i    (wb_res),
    .ll_valid_i     (ll_valid),
    .ll_ready_o     (ll_ready),
    .ll_rd_i        (ll_rd),
    .ll_result_i    (ll_res),
    .a3_o           (a3),
    .wd3_o          (wd3),
    .we3_o          (we3),
    .pending_o      (pending),
    .stall_o        (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        ll_v;
    logic [4:0]  ll_rd;
    logic [31:0] ll_res;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic [31:0] e_pend;
    logic        e_stall;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] rd,
                       input logic [31:0] res, input logic v, input logic [4:0] lrd,
                       input logic [31:0] lres);
    reset    = r;
    wb_we    = we;
    wb_rd    = rd;
    wb_res   = res;
    ll_valid = v;
    ll_rd    = lrd;
    ll_res   = lres;
    #2;
  endtask

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic e_we, input logic [4:0] e_a3,
                            input logic [31:0] e_wd);
    check({tag, ".we3"}, 32'(we3), 32'(e_we));
    if (e_we) begin
      check({tag, ".a3"}, 32'(a3), 32'(e_a3));
      check({tag, ".wd3"}, wd3, e_wd);
    end
  endtask

  initial begin
    // Table: each row is one cycle; outputs checked before the closing edge.
    vecs[0]  = '{1'b1, 1'b1, 5'd5, 32'h0BAD0001, 1'b1, 5'd3, 32'h33,
                 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 5'd0, 32'h1111, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 5'd7, 32'h1234, 1'b1, 32'h80, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hA,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hB,
                 1'b1, 5'd9, 32'hA, 1'b1, 32'h200, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF,
                 1'b1, 5'd9, 32'hB, 1'b1, 32'h200, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44,
                 1'b1, 5'd3, 32'h33, 1'b1, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,
                 1'b1, 5'd6, 32'h66, 1'b1, 32'h10, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b1, 5'd4, 32'h44, 1'b1, 32'h10, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b0};

    // Initial reset so every register is defined before the table starts.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_res,
            vecs[i].ll_v, vecs[i].ll_rd, vecs[i].ll_res);
      check_port($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_a3, vecs[i].e_wd);
      check($sformatf("vec%0d.ready", i), 32'(ll_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d.pending", i), pending, vecs[i].e_pend);
      check($sformatf("vec%0d.stall", i), 32'(stall), 32'(vecs[i].e_stall));
      tick();
    end

    // Fill with the pipeline holding the port, then drain in order.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b1, 5'd20, 32'h2020, 1'b1, 5'(k), 32'h100 + 32'(k));
      check_port($sformatf("fill%0d", k), 1'b1, 5'd20, 32'h2020);
      check($sformatf("fill%0d.ready", k), 32'(ll_ready), 32'd1);
      check($sformatf("fill%0d.pending", k), pending, (32'd1 << k) - 32'd2);
      tick();
    end
    drive(1'b0, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'h0);
    check("full.ready", 32'(ll_ready), 32'd0);
    check("full.pending", pending, 32'h1E);
    check_port("full", 1'b1, 5'd20, 32'h2020);
    tick();
    for (int k = 1; k <= 4; k++) begin
      // An offer while full must be refused.
      drive(1'b0, 1'b0, 5'd0, 32'h0, (k == 1), 5'd5, 32'h55);
      check_port($sformatf("drain%0d", k), 1'b1, 5'(k), 32'h100 + 32'(k));
      check($sformatf("drain%0d.ready", k), 32'(ll_ready), (k == 1) ? 32'd0 : 32'd1);
      check($sformatf("drain%0d.pending", k), pending, 32'h1E & ~((32'd1 << k) - 32'd1));
      check($sformatf("drain%0d.stall", k), 32'(stall), 32'd0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("drained.we3", 32'(we3), 32'd0);
    check("drained.pending", pending, 32'h0);
    tick();

    // Starvation: one entry blocked for eight edges.
    drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd10, 32'hAA);
    tick();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
      check($sformatf("starve%0d.stall", k), 32'(stall), 32'd0);
      check($sformatf("starve%0d.pending", k), pending, 32'h400);
      tick();
    end
    drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
    check("starved.stall", 32'(stall), 32'd1);
    check_port("starved", 1'b1, 5'd2, 32'h22);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("unstarve.stall", 32'(stall), 32'd1);
    check_port("unstarve", 1'b1, 5'd10, 32'hAA);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("after_starve.stall", 32'(stall), 32'd0);
    check("after_starve.we3", 32'(we3), 32'd0);
    check("after_starve.pending", pending, 32'h0);
    tick();

    // Reset mid-operation with three entries queued and stall raised.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'(11 + k), 32'hC0 + 32'(k));
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
      tick();
    end
    drive(1'b0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0);
    check("prerst.stall", 32'(stall), 32'd1);
    check("prerst.pending", pending, 32'h3800);
    check("prerst.ready", 32'(ll_ready), 32'd1);
    tick();
    drive(1'b1, 1'b1, 5'd2, 32'h22, 1'b1, 5'd14, 32'hEE);
    check("inrst.we3", 32'(we3), 32'd0);
    check("inrst.ready", 32'(ll_ready), 32'd0);
    check("inrst.stall", 32'(stall), 32'd0);
    check("inrst.pending", pending, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("postrst.pending", pending, 32'h0);
    check("postrst.stall", 32'(stall), 32'd0);
    check("postrst.ready", 32'(ll_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("postrst%0d.we3", k), 32'(we3), 32'd0);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
